// File: rtl/agm_fetch_unit_if.sv
// agm_fetch_unit_if: program-memory byte port and instruction valid/ready port of the fetch unit.
interface agm_fetch_unit_if #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int INSTR_BYTES = 3
);
  logic                          mem_req;
  logic [ADDR_W-1:0]             mem_addr;
  logic                          mem_ack;
  logic [DATA_W-1:0]             mem_rdata;
  logic                          instr_valid;
  logic                          instr_ready;
  logic [DATA_W*INSTR_BYTES-1:0] instr_out;
  logic [ADDR_W-1:0]             instr_pc;
  modport master (
    output mem_req, mem_addr, instr_valid, instr_out, instr_pc,
    input  mem_ack, mem_rdata, instr_ready
  );
  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_out, instr_pc,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/agm_fetch_unit.sv
// agm_fetch_unit: byte-wise instruction fetch, word assembly and prefetch queue with redirect flush.
module agm_fetch_unit #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int INSTR_BYTES = 3,
  parameter int QDEPTH      = 2,
  parameter int RESET_PC    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_en,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic [ADDR_W-1:0]            pc_out,
  output logic [1:0]                   state_out,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count,
  agm_fetch_unit_if.master             bus
);
  localparam int IW = DATA_W * INSTR_BYTES;
  localparam int BW = $clog2(INSTR_BYTES + 1);
  localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FULL = 2'd2} state_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, start_pc;
  logic [BW-1:0]     cnt;
  logic [IW-1:0]     asm_q;
  logic [IW+DATA_W-1:0] shifted;
  logic [IW-1:0]     q_data [QDEPTH];
  logic [ADDR_W-1:0] q_pc [QDEPTH];
  logic [PW-1:0]     rd, wr;
  logic [CW-1:0]     count;
  logic              valid, take, last, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(QDEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign shifted         = {asm_q, bus.mem_rdata};
  assign valid           = count != '0;
  assign take            = state == FETCH && bus.mem_ack && !redirect;
  assign last            = cnt == BW'(INSTR_BYTES - 1);
  assign push            = take && last;
  assign pop             = valid && bus.instr_ready && !redirect;
  assign bus.mem_req     = state == FETCH;
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = valid;
  assign bus.instr_out   = valid ? q_data[rd] : '0;
  assign bus.instr_pc    = valid ? q_pc[rd] : '0;
  assign pc_out          = pc;
  assign state_out       = state;
  assign q_count         = count;
  // A push that fills the queue wins over fetch_en=0 so a full queue always reads as FULL.
  always_comb begin
    state_nx = state;
    if (redirect) state_nx = fetch_en ? FETCH : IDLE;
    else if (state == IDLE) state_nx = fetch_en ? FETCH : IDLE;
    else if (state == FETCH) state_nx = (push && !pop && count == CW'(QDEPTH - 1)) ? FULL : (fetch_en ? FETCH : IDLE);
    else state_nx = pop ? FETCH : FULL;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= ADDR_W'(RESET_PC);
      start_pc <= '0;
      cnt      <= '0;
      asm_q    <= '0;
      rd       <= '0;
      wr       <= '0;
      count    <= '0;
    end else begin
      state <= state_nx;
      if (redirect) begin
        pc    <= redirect_pc;
        cnt   <= '0;
        asm_q <= '0;
        rd    <= '0;
        wr    <= '0;
        count <= '0;
      end else begin
        if (take) begin
          pc    <= pc + 1'b1;
          asm_q <= shifted[IW-1:0];
          cnt   <= last ? '0 : cnt + 1'b1;
          if (cnt == '0) start_pc <= pc;
        end
        if (push) begin
          q_data[wr] <= shifted[IW-1:0];
          q_pc[wr]   <= cnt == '0 ? pc : start_pc;
          wr         <= nxt(wr);
        end
        if (pop) rd <= nxt(rd);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_agm_fetch_unit.sv
// tb_agm_fetch_unit: directed test-plan steps then random traffic against an instruction-stream scoreboard.
module tb_agm_fetch_unit;
  logic clk = 0;
  logic rst = 0;
  logic fetch_en = 0, redirect = 0;
  logic [7:0] redirect_pc = 0;
  logic [7:0] pc_out, pc2;
  logic [1:0] state_out, st2, qc2;
  logic [1:0] q_count;
  logic fe2 = 0;
  logic [7:0] mem [256];
  int vectors = 0, errors = 0;
  logic [7:0] fa, exp_pc;
  int nb, q, es;

  agm_fetch_unit_if #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(3)) bus ();
  agm_fetch_unit_if #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(3)) bus2 ();

  agm_fetch_unit #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(3), .QDEPTH(2), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_out(pc_out), .state_out(state_out), .q_count(q_count), .bus(bus.master));

  agm_fetch_unit #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(3), .QDEPTH(2), .RESET_PC(8'hFE)) dut_fe (
    .clk(clk), .rst(rst), .fetch_en(fe2), .redirect(1'b0), .redirect_pc(8'h00),
    .pc_out(pc2), .state_out(st2), .q_count(qc2), .bus(bus2.master));

  assign bus2.mem_ack     = bus2.mem_req;
  assign bus2.mem_rdata   = mem[bus2.mem_addr];
  assign bus2.instr_ready = 1'b0;
  assign bus.mem_rdata    = mem[bus.mem_addr];

  always #5 clk = ~clk;

  function automatic logic [23:0] word(input logic [7:0] p);
    logic [7:0] p1, p2;
    p1 = p + 8'd1;
    p2 = p + 8'd2;
    return {mem[p], mem[p1], mem[p2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("state", 32'(state_out), 32'(es));
    chk("mem_req", 32'(bus.mem_req), 32'(es == 1));
    chk("mem_addr", 32'(bus.mem_addr), 32'(fa));
    chk("pc_out", 32'(pc_out), 32'(fa));
    chk("q_count", 32'(q_count), 32'(q));
    chk("valid", 32'(bus.instr_valid), 32'(q != 0));
    if (q != 0) begin
      chk("instr_pc", 32'(bus.instr_pc), 32'(exp_pc));
      chk("instr_out", 32'(bus.instr_out), 32'(word(exp_pc)));
    end
  endtask

  task automatic do_reset(input bit hostile);
    rst = 0;
    fetch_en = hostile;
    bus.mem_ack = hostile;
    bus.instr_ready = hostile;
    redirect = hostile;
    redirect_pc = 8'h77;
    @(negedge clk);
    rst = 1;
    fetch_en = 0;
    bus.mem_ack = 0;
    bus.instr_ready = 0;
    redirect = 0;
    fa = 8'h00; exp_pc = 8'h00; nb = 0; q = 0; es = 0;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_out", 32'(bus.instr_out), 32'd0);
    chk("rst_ipc", 32'(bus.instr_pc), 32'd0);
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
  endtask

  task automatic step(input bit fe, input bit ack, input bit rdy, input bit rd, input logic [7:0] rpc);
    bit push, pop;
    int qn;
    fetch_en = fe;
    bus.mem_ack = ack && es == 1;
    bus.instr_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    if (rd) begin
      fa = rpc; exp_pc = rpc; nb = 0; q = 0; es = fe ? 1 : 0;
    end else begin
      push = 0;
      if (ack && es == 1) begin
        fa++;
        nb++;
        if (nb == 3) begin nb = 0; push = 1; end
      end
      pop = q != 0 && rdy;
      if (pop) exp_pc = exp_pc + 8'd3;
      qn = q + int'(push) - int'(pop);
      if (es == 2) es = pop ? 1 : 2;
      else if (push && !pop && qn == 2) es = 2;
      else es = fe ? 1 : 0;
      q = qn;
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    bus.mem_ack = 0;
    bus.instr_ready = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    mem[3] = 8'h11; mem[4] = 8'h21; mem[5] = 8'h31;
    do_reset(0);
    fe2 = 1;
    step(1, 1, 1, 0, 8'h00);
    chk("t1_req_rise", 32'(bus.mem_req), 32'd1);
    step(1, 1, 1, 0, 8'h00);
    step(1, 1, 1, 0, 8'h00);
    chk("t1_not_yet", 32'(bus.instr_valid), 32'd0);
    step(1, 1, 1, 0, 8'h00);
    chk("t1_w0", 32'(bus.instr_out), 32'h102030);
    chk("t1_pc0", 32'(bus.instr_pc), 32'h00);
    chk("fe_valid", 32'(bus2.instr_valid), 32'd1);
    chk("fe_ipc", 32'(bus2.instr_pc), 32'hFE);
    chk("fe_word", 32'(bus2.instr_out), 32'(word(8'hFE)));
    chk("fe_pc_out", 32'(pc2), 32'h01);
    step(1, 1, 1, 0, 8'h00);
    chk("t1_gap", 32'(bus.instr_valid), 32'd0);
    step(1, 1, 1, 0, 8'h00);
    step(1, 1, 1, 0, 8'h00);
    chk("t1_w1", 32'(bus.instr_out), 32'h112131);
    chk("t1_pc1", 32'(bus.instr_pc), 32'h03);
    step(1, 0, 0, 1, 8'h00);
    repeat (6) step(1, 1, 0, 0, 8'h00);
    chk("t2_count", 32'(q_count), 32'd2);
    chk("t2_state", 32'(state_out), 32'd2);
    chk("t2_req", 32'(bus.mem_req), 32'd0);
    step(1, 0, 1, 0, 8'h00);
    chk("t2_resume_state", 32'(state_out), 32'd1);
    chk("t2_resume_req", 32'(bus.mem_req), 32'd1);
    step(1, 0, 0, 1, 8'h80);
    step(1, 1, 0, 0, 8'h00);
    step(1, 1, 0, 1, 8'h40);
    chk("t3_empty", 32'(q_count), 32'd0);
    chk("t3_addr", 32'(bus.mem_addr), 32'h40);
    chk("t3_req", 32'(bus.mem_req), 32'd1);
    repeat (3) step(1, 1, 0, 0, 8'h00);
    chk("t3_pc", 32'(bus.instr_pc), 32'h40);
    chk("t3_word", 32'(bus.instr_out), 32'(word(8'h40)));
    repeat (2) step(1, 1, 0, 0, 8'h00);
    step(1, 1, 1, 0, 8'h00);
    chk("t4_count", 32'(q_count), 32'd1);
    chk("t4_order", 32'(bus.instr_pc), 32'h43);
    repeat (3) step(1, 1, 0, 0, 8'h00);
    chk("t5_full", 32'(q_count), 32'd2);
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] rpc;
      r = $urandom_range(0, 499);
      rpc = $urandom_range(0, 1) != 0 ? 8'($urandom_range(250, 255)) : 8'($urandom);
      if (r == 0) do_reset(1);
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 40) == 0, rpc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
